// File: rtl/usb_pkg.sv
// Shared USB constants, endpoint FSM state type and endpoint-number decode helpers.
package usb_pkg;

  localparam logic [3:0] HSK_ACK   = 4'b0010;
  localparam logic [3:0] HSK_NAK   = 4'b1010;
  localparam logic [3:0] HSK_STALL = 4'b1110;
  localparam logic [3:0] HSK_NYET  = 4'b0110;

  localparam logic [1:0] TOK_SETUP = 2'b11;
  localparam logic [1:0] TOK_IN    = 2'b10;
  localparam logic [1:0] TOK_OUT   = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IN_ACT,
    ST_OUT_ACT,
    ST_OUT_DROP
  } ep_state_e;

  // One-hot of (ep - base); all zero when ep is below base or beyond the last endpoint.
  function automatic logic [15:0] ep_onehot(input logic [3:0] ep, input int base, input int num);
    int d;
    d = int'(ep) - base;
    if (d >= 0 && d < num) return 16'd1 << d;
    return 16'd0;
  endfunction

  function automatic logic [3:0] ep_index(input logic [3:0] ep, input int base);
    return ep - 4'(base);
  endfunction

endpackage

// File: rtl/usb_ep_mux.sv
// Routes usb_xfer bulk IN/OUT traffic to NUM_EPS application endpoints; data paths are
// combinational, completion/abort pulses are registered one cycle after their cause.
module usb_ep_mux #(
  parameter int NUM_EPS = 2,
  parameter int EP_BASE = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   trn_start_i,
  input  logic [3:0]             trn_endpoint_i,
  input  logic                   blk_in_xfer_i,
  input  logic                   blk_out_xfer_i,
  input  logic [3:0]             blk_xfer_endpoint_i,
  output logic                   bid_has_data_o,
  output logic                   bid_tvalid_o,
  output logic                   bid_tlast_o,
  output logic [7:0]             bid_tdata_o,
  input  logic                   bid_tready_i,
  output logic                   blk_xfer_out_ready_read_o,
  input  logic [7:0]             blk_xfer_out_data_i,
  input  logic                   blk_xfer_out_data_valid_i,
  input  logic [NUM_EPS-1:0]     ep_has_data_i,
  input  logic [NUM_EPS-1:0]     ep_tvalid_i,
  input  logic [NUM_EPS-1:0]     ep_tlast_i,
  input  logic [8*NUM_EPS-1:0]   ep_tdata_i,
  output logic [NUM_EPS-1:0]     ep_tready_o,
  input  logic [NUM_EPS-1:0]     ep_out_ready_i,
  output logic [NUM_EPS-1:0]     ep_out_tvalid_o,
  output logic [7:0]             ep_out_tdata_o,
  output logic [NUM_EPS-1:0]     ep_out_end_o,
  output logic [NUM_EPS-1:0]     ep_in_done_o,
  output logic [NUM_EPS-1:0]     ep_in_abort_o
);
  import usb_pkg::*;

  ep_state_e        state;
  logic [3:0]       sel;
  logic [3:0]       pend_sel;
  logic             out_ok;
  logic             out_q;
  logic             mid;

  logic [NUM_EPS-1:0] tok_m;
  logic [NUM_EPS-1:0] in_m;
  logic [NUM_EPS-1:0] sel_m;
  logic [NUM_EPS-1:0] pend_m;
  logic [NUM_EPS-1:0] out_m;
  logic               in_beat;
  logic               out_rise;
  logic               out_live;

  assign tok_m  = NUM_EPS'(ep_onehot(trn_endpoint_i, EP_BASE, NUM_EPS));
  assign in_m   = blk_in_xfer_i ? NUM_EPS'(ep_onehot(blk_xfer_endpoint_i, EP_BASE, NUM_EPS)) : '0;
  assign sel_m  = NUM_EPS'(16'd1 << sel);
  assign pend_m = NUM_EPS'(16'd1 << pend_sel);

  // Token-time answers must be valid in the same cycle as trn_start_i.
  assign bid_has_data_o            = |(ep_has_data_i & tok_m);
  assign blk_xfer_out_ready_read_o = |(ep_out_ready_i & tok_m);

  assign bid_tvalid_o = |(ep_tvalid_i & in_m);
  assign bid_tlast_o  = |(ep_tlast_i & in_m);
  assign ep_tready_o  = bid_tready_i ? in_m : '0;
  assign in_beat      = bid_tvalid_o & bid_tready_i;

  always_comb begin
    bid_tdata_o = '0;
    for (int i = 0; i < NUM_EPS; i++) begin
      if (in_m[i]) bid_tdata_o = ep_tdata_i[8*i +: 8];
    end
  end

  // A byte arriving on the very cycle the OUT session rises still reaches the latched sink.
  assign out_rise = blk_out_xfer_i & ~out_q;
  assign out_live = (state == ST_OUT_ACT) ||
                    (state == ST_IDLE && !blk_in_xfer_i && out_rise && out_ok);
  assign out_m    = (state == ST_OUT_ACT) ? sel_m : pend_m;
  assign ep_out_tvalid_o = (out_live && blk_out_xfer_i && blk_xfer_out_data_valid_i) ? out_m : '0;
  assign ep_out_tdata_o  = blk_xfer_out_data_i;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      sel           <= '0;
      pend_sel      <= '0;
      out_ok        <= 1'b0;
      out_q         <= 1'b0;
      mid           <= 1'b0;
      ep_in_done_o  <= '0;
      ep_in_abort_o <= '0;
      ep_out_end_o  <= '0;
    end else begin
      out_q         <= blk_out_xfer_i;
      ep_in_done_o  <= '0;
      ep_in_abort_o <= '0;
      ep_out_end_o  <= '0;
      if (trn_start_i) begin
        pend_sel <= ep_index(trn_endpoint_i, EP_BASE);
        out_ok   <= blk_xfer_out_ready_read_o;
      end
      case (state)
        ST_IDLE: begin
          if (blk_in_xfer_i) begin
            state <= ST_IN_ACT;
            sel   <= ep_index(blk_xfer_endpoint_i, EP_BASE);
            if (in_beat) begin
              mid <= ~bid_tlast_o;
              if (bid_tlast_o) ep_in_done_o <= in_m;
            end
          end else if (out_rise) begin
            state <= out_ok ? ST_OUT_ACT : ST_OUT_DROP;
            sel   <= pend_sel;
          end
        end
        ST_IN_ACT: begin
          if (!blk_in_xfer_i) begin
            state <= ST_IDLE;
            mid   <= 1'b0;
            if (mid) ep_in_abort_o <= sel_m;
          end else if (in_beat) begin
            mid <= ~bid_tlast_o;
            if (bid_tlast_o) ep_in_done_o <= sel_m;
          end
        end
        ST_OUT_ACT: begin
          if (!blk_out_xfer_i) begin
            state        <= ST_IDLE;
            ep_out_end_o <= sel_m;
          end
        end
        ST_OUT_DROP: begin
          if (!blk_out_xfer_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/usb_ep_mux.md
# usb_ep_mux

Endpoint router between `usb_xfer` and up to `NUM_EPS` application bulk endpoints. For IN, it selects the addressed endpoint's AXI-S source onto the single `bid_*` port. For OUT, it demultiplexes `blk_xfer_out_*` bytes to the addressed sink. It answers `usb_xfer`'s token-time queries (`bid_has_data`, `blk_xfer_out_ready_read`) from the token's endpoint number, and reports per-endpoint packet completion and abort.

## Interface
Parameters:
- `NUM_EPS`, default 2: number of application bulk endpoints, 1..15.
- `EP_BASE`, default 1: USB endpoint number of index 0. Index i serves EP `EP_BASE+i`.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high.
- `trn_start_i`  in  1  token strobe from the packet decoder.
- `trn_endpoint_i`  in  4  token endpoint.
- `blk_in_xfer_i`  in  1  `usb_xfer` bulk-IN session active.
- `blk_out_xfer_i`  in  1  `usb_xfer` bulk-OUT session active.
- `blk_xfer_endpoint_i`  in  4  `usb_xfer` current endpoint.
- `bid_has_data_o`  out  1  addressed IN endpoint has a packet.
- `bid_tvalid_o`, `bid_tlast_o`  out  1  muxed IN stream.
- `bid_tdata_o`  out  8  muxed IN stream data.
- `bid_tready_i`  in  1  IN stream ready from `usb_xfer`.
- `blk_xfer_out_ready_read_o`  out  1  addressed OUT endpoint can take a full packet.
- `blk_xfer_out_data_i`  in  8  OUT data byte.
- `blk_xfer_out_data_valid_i`  in  1  OUT data byte valid.
- `ep_has_data_i`  in  NUM_EPS  per-endpoint IN packet available.
- `ep_tvalid_i`, `ep_tlast_i`  in  NUM_EPS  per-endpoint IN stream.
- `ep_tdata_i`  in  8*NUM_EPS  per-endpoint IN data; index i is at [8i+7:8i].
- `ep_tready_o`  out  NUM_EPS  per-endpoint IN ready.
- `ep_out_ready_i`  in  NUM_EPS  per-endpoint OUT space for one max packet.
- `ep_out_tvalid_o`  out  NUM_EPS  per-endpoint OUT byte strobe.
- `ep_out_tdata_o`  out  8  OUT byte, shared by all endpoints.
- `ep_out_end_o`  out  NUM_EPS  one-cycle pulse: accepted OUT packet finished.
- `ep_in_done_o`  out  NUM_EPS  one-cycle pulse: IN tlast beat transferred.
- `ep_in_abort_o`  out  NUM_EPS  one-cycle pulse: IN session ended mid-packet.

## Operation
- Index decode: `idx = ep - EP_BASE`. It is valid iff `ep >= EP_BASE` and `idx < NUM_EPS`. An invalid endpoint reads `has_data = 0` and `out_ready = 0`, so `usb_xfer` NAKs.
- `bid_has_data_o` and `blk_xfer_out_ready_read_o` are combinational from `trn_endpoint_i`, because `usb_xfer` samples them in the same cycle as `trn_start_i`.
- IN mux is combinational on `blk_xfer_endpoint_i`, gated by `blk_in_xfer_i`. `ep_tready_o[idx] = blk_in_xfer_i & bid_tready_i`; all other bits are 0. `bid_tvalid_o = 0` when `blk_in_xfer_i` is low or idx is invalid.
- FSM states: IDLE, IN_ACT, OUT_ACT, OUT_DROP.
  - IDLE→IN_ACT on `blk_in_xfer_i`; latch idx into `sel`.
  - IDLE→OUT_ACT on `trn_start_i` with OUT type implied by `blk_out_xfer_i` rising next cycle, and `out_ready` true; latch `sel`.
  - IDLE→OUT_DROP when that `out_ready` is false.
  - IN_ACT→IDLE when `blk_in_xfer_i` falls.
  - OUT_ACT and OUT_DROP→IDLE when `blk_out_xfer_i` falls.
- Implementation of OUT latching: register `out_ok` and `sel` on every `trn_start_i`; enter OUT_ACT or OUT_DROP on the rising edge of `blk_out_xfer_i`.
- In OUT_ACT, `ep_out_tvalid_o[sel] = blk_xfer_out_data_valid_i`. In OUT_DROP, bytes are discarded, because `usb_xfer` streams NAKed payloads too.
- `mid` flag in IN_ACT: set on a beat with `tlast = 0`; cleared on a beat with `tlast = 1`, which also pulses `ep_in_done_o[sel]` on the next cycle.
- On IN_ACT→IDLE with `mid = 1`, pulse `ep_in_abort_o[sel]` and clear `mid`. A zero-length session (no beats) gives no pulse.
- On OUT_ACT→IDLE, pulse `ep_out_end_o[sel]`. OUT_DROP→IDLE gives no pulse.
- `ep_out_tdata_o = blk_xfer_out_data_i` (pass-through).

## Timing
- Data paths are zero latency, combinational. Status pulses are registered: 1 cycle after the beat or edge that causes them, and high for exactly 1 cycle.
- Reset: FSM in IDLE, `sel = 0`, `mid = 0`, `out_ok = 0`, every pulse output 0. Combinational outputs follow their inputs.
- Simultaneous tlast beat and `blk_in_xfer_i` fall: done pulses, abort does not.
- Reset mid-session: no abort or end pulse is emitted.
- `blk_xfer_endpoint_i` changing while IN_ACT: ignored for status; status uses `sel`.

## Structure
- Shared package `usb_pkg`: HSK_* constants, token-type codes (SETUP=2'b11, IN=2'b10, OUT=2'b00), and an endpoint-index decode function.
- No sub-module; the one-hot decoder is a function from the package.

## Test plan
- EP_BASE=1, NUM_EPS=2, token EP2, `ep_has_data_i = 2'b10` → `bid_has_data_o = 1`. Stream 4 bytes A0..A3 with tlast on A3 → bytes appear on `bid_tdata_o`; `ep_in_done_o = 2'b10` for 1 cycle.
- IN on EP1; `blk_in_xfer_i` drops after 2 of 5 bytes → `ep_in_abort_o = 2'b01`, no done pulse.
- OUT token EP1 with `ep_out_ready_i = 2'b01`, then 8 bytes → `ep_out_tvalid_o[0]` strobes 8 times; `ep_out_end_o = 2'b01` after the session falls.
- OUT token EP2 with `ep_out_ready_i[1] = 0` → `ready_read_o = 0`; 8 NAKed bytes produce no strobe and no end pulse.
- Token EP0 and token EP5 → `has_data = 0`, `ready = 0`, no stream activity. Reset asserted mid-IN → no pulses; FSM returns to IDLE.
